phys_reg_free_list: RTL and testbench

- Physical-register free list for the 2-wide rename stage.
- Hands rename up to two free physical tags per cycle, plus a live free-tag bitmap.
- Reclaims up to two old destination tags per cycle from writeback/retire.
- Circular FIFO of 6-bit tags; lets rename stop computing free registers from a flat vector.

---
 rtl/phys_reg_free_list_pkg.sv | 16 +
 rtl/phys_reg_free_list_ram.sv | 39 +++
 rtl/phys_reg_free_list.sv | 127 ++++++++++++
 tb/tb_phys_reg_free_list.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// Shared types and sizing for the physical-register free list and its clients.
package phys_reg_free_list_pkg;

  localparam int PHYS_TAG_W    = 6;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

  // One release slot as driven by writeback/retire.
  typedef struct packed {
    logic      valid;
    phys_tag_t tag;
  } free_rel_t;

endpackage

// File: rtl/phys_reg_free_list_ram.sv
// Tag storage for the free list: circular array with two async reads and two writes.
module free_list_ram
  import phys_reg_free_list_pkg::*;
#(
  parameter int DEPTH      = NUM_PHYS_REGS,
  parameter int TAG_W      = PHYS_TAG_W,
  parameter int RESET_BASE = NUM_ARCH_REGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] rd_addr_1,
  input  logic [TAG_W-1:0] rd_addr_2,
  output logic [TAG_W-1:0] rd_data_1,
  output logic [TAG_W-1:0] rd_data_2,
  input  logic             wr_en_1,
  input  logic [TAG_W-1:0] wr_addr_1,
  input  logic [TAG_W-1:0] wr_data_1,
  input  logic             wr_en_2,
  input  logic [TAG_W-1:0] wr_addr_2,
  input  logic [TAG_W-1:0] wr_data_2
);

  logic [TAG_W-1:0] mem [DEPTH];

  // NOTE: this array is reset on purpose -- the initial free tags live in it,
  // so it must come out of reset holding them; that forces flops, not SRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'((RESET_BASE + i) % DEPTH);
    end else begin
      if (wr_en_1) mem[wr_addr_1] <= wr_data_1;
      if (wr_en_2) mem[wr_addr_2] <= wr_data_2;
    end
  end

  assign rd_data_1 = mem[rd_addr_1];
  assign rd_data_2 = mem[rd_addr_2];

endmodule

// File: rtl/phys_reg_free_list.sv
// 2-wide physical-register free list: zero-latency allocation, two releases per cycle.
// Optional double-free/overflow checking is enabled with `define FREELIST_CHECK_EN.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int NUM_PHYS = NUM_PHYS_REGS,
  parameter int NUM_ARCH = NUM_ARCH_REGS,
  parameter int TAG_W    = PHYS_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req_1,
  input  logic                alloc_req_2,
  output logic                alloc_ok,
  output logic [TAG_W-1:0]    alloc_tag_1,
  output logic [TAG_W-1:0]    alloc_tag_2,
  input  logic                rel_valid_1,
  input  logic [TAG_W-1:0]    rel_tag_1,
  input  logic                rel_valid_2,
  input  logic [TAG_W-1:0]    rel_tag_2,
  output logic [TAG_W:0]      free_count,
  output logic [NUM_PHYS-1:0] free_regs,
  output logic                err_double_free
);

  localparam logic [TAG_W:0]      FULL       = (TAG_W+1)'(NUM_PHYS);
  localparam logic [NUM_PHYS-1:0] RESET_REGS = {NUM_PHYS{1'b1}} << NUM_ARCH;

  logic [TAG_W-1:0]    head, tail;
  logic [TAG_W-1:0]    rd_1, rd_2;
  logic [1:0]          need, granted, accepted;
  logic                grant_1, grant_2;
  free_rel_t           rel_1, rel_2;
  logic                live_1, live_2, full_1, full_2, dup_1, dup_2, acc_1, acc_2;
  logic [NUM_PHYS-1:0] alloc_mask, rel_mask;

  assign rel_1 = '{valid: rel_valid_1, tag: phys_tag_t'(rel_tag_1)};
  assign rel_2 = '{valid: rel_valid_2, tag: phys_tag_t'(rel_tag_2)};

  // Allocation is all-or-nothing against the pre-edge count.
  assign need        = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
  assign alloc_ok    = free_count >= (TAG_W+1)'(need);
  assign grant_1     = alloc_ok & alloc_req_1;
  assign grant_2     = alloc_ok & alloc_req_2;
  assign granted     = {1'b0, grant_1} + {1'b0, grant_2};
  assign alloc_tag_1 = rd_1;
  assign alloc_tag_2 = alloc_req_1 ? rd_2 : rd_1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    live_1 = rel_1.valid && (rel_1.tag != '0);
    live_2 = rel_2.valid && (rel_2.tag != '0);
    dup_1  = 1'b0;
    dup_2  = 1'b0;
`ifdef FREELIST_CHECK_EN
    dup_1  = free_regs[rel_1.tag];
    dup_2  = free_regs[rel_2.tag] || (rel_1.valid && (rel_1.tag == rel_2.tag));
`endif
    full_1 = (free_count == FULL);
    acc_1  = live_1 && !full_1 && !dup_1;
    // Slot 2 only fits if slot 1 did not take the last free entry.
    full_2 = ((free_count + (TAG_W+1)'(acc_1)) >= FULL);
    acc_2  = live_2 && !full_2 && !dup_2;
  end

  assign accepted = {1'b0, acc_1} + {1'b0, acc_2};

  always_comb begin
    alloc_mask = '0;
    rel_mask   = '0;
    if (grant_1) alloc_mask[alloc_tag_1] = 1'b1;
    if (grant_2) alloc_mask[alloc_tag_2] = 1'b1;
    if (acc_1)   rel_mask[rel_1.tag]     = 1'b1;
    if (acc_2)   rel_mask[rel_2.tag]     = 1'b1;
  end

  free_list_ram #(
    .DEPTH      (NUM_PHYS),
    .TAG_W      (TAG_W),
    .RESET_BASE (NUM_ARCH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_1 (head),
    .rd_addr_2 (head + TAG_W'(1)),
    .rd_data_1 (rd_1),
    .rd_data_2 (rd_2),
    .wr_en_1   (acc_1),
    .wr_addr_1 (tail),
    .wr_data_1 (rel_1.tag),
    .wr_en_2   (acc_2),
    .wr_addr_2 (tail + TAG_W'(acc_1)),
    .wr_data_2 (rel_2.tag)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= TAG_W'(NUM_PHYS - NUM_ARCH);
      free_count <= (TAG_W+1)'(NUM_PHYS - NUM_ARCH);
      free_regs  <= RESET_REGS;
    end else begin
      head       <= head + TAG_W'(granted);
      tail       <= tail + TAG_W'(accepted);
      free_count <= free_count - (TAG_W+1)'(granted) + (TAG_W+1)'(accepted);
      free_regs  <= (free_regs & ~alloc_mask) | rel_mask;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((live_1 && (dup_1 || full_1)) || (live_2 && (dup_2 || full_2))) begin
      err_q <= 1'b1;
    end
  end

  assign err_double_free = err_q;
`else
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: driver queues expectations, negedge monitor compares.
module tb_phys_reg_free_list;

`ifdef FREELIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req_1, alloc_req_2, alloc_ok;
  logic [5:0]  alloc_tag_1, alloc_tag_2;
  logic        rel_valid_1, rel_valid_2;
  logic [5:0]  rel_tag_1, rel_tag_2;
  logic [6:0]  free_count;
  logic [63:0] free_regs;
  logic        err_double_free;

  phys_reg_free_list dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req_1     (alloc_req_1),
    .alloc_req_2     (alloc_req_2),
    .alloc_ok        (alloc_ok),
    .alloc_tag_1     (alloc_tag_1),
    .alloc_tag_2     (alloc_tag_2),
    .rel_valid_1     (rel_valid_1),
    .rel_tag_1       (rel_tag_1),
    .rel_valid_2     (rel_valid_2),
    .rel_tag_2       (rel_tag_2),
    .free_count      (free_count),
    .free_regs       (free_regs),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  // A field set to -1 (or c_regs=0) is not compared for that vector.
  typedef struct {
    string       name;
    int          ok;
    int          t1;
    int          t2;
    int          cnt;
    int          err;
    bit          c_regs;
    logic [63:0] regs;
  } exp_t;

  localparam logic [63:0] RST_REGS = 64'hFFFF_FFFF_0000_0000;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic exp_push(input string name, input int ok, input int t1, input int t2,
                          input int cnt, input int err, input bit c_regs = 1'b0,
                          input logic [63:0] regs = '0);
    exp_t e;
    e = '{name: name, ok: ok, t1: t1, t2: t2, cnt: cnt, err: err, c_regs: c_regs, regs: regs};
    exp_q.push_back(e);
  endtask

  task automatic apply(input bit r1, input bit r2, input bit v1, input int t1,
                       input bit v2, input int t2);
    @(posedge clk);
    #1;
    alloc_req_1 = r1;
    alloc_req_2 = r2;
    rel_valid_1 = v1;
    rel_tag_1   = 6'(t1);
    rel_valid_2 = v2;
    rel_tag_2   = 6'(t2);
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.ok  >= 0) check({mon_e.name, ".alloc_ok"},    64'(alloc_ok),        64'(mon_e.ok));
      if (mon_e.t1  >= 0) check({mon_e.name, ".alloc_tag_1"}, 64'(alloc_tag_1),     64'(mon_e.t1));
      if (mon_e.t2  >= 0) check({mon_e.name, ".alloc_tag_2"}, 64'(alloc_tag_2),     64'(mon_e.t2));
      if (mon_e.cnt >= 0) check({mon_e.name, ".free_count"},  64'(free_count),      64'(mon_e.cnt));
      if (mon_e.err >= 0) check({mon_e.name, ".err"},         64'(err_double_free), 64'(mon_e.err));
      if (mon_e.c_regs)   check({mon_e.name, ".free_regs"},   free_regs,            mon_e.regs);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    alloc_req_1 = 1'b0; alloc_req_2 = 1'b0;
    rel_valid_1 = 1'b0; rel_valid_2 = 1'b0;
    rel_tag_1   = '0;   rel_tag_2   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_push("reset", 1, 32, -1, 32, 0, 1'b1, RST_REGS);

    // Drain the whole initial pool two tags per cycle.
    for (int k = 0; k < 16; k++) begin
      apply(1, 1, 0, 0, 0, 0);
      exp_push($sformatf("burst%0d", k), 1, 32 + 2*k, 33 + 2*k, 32 - 2*k, 0);
    end
    apply(1, 1, 0, 0, 0, 0);
    exp_push("empty_deny", 0, -1, -1, 0, -1, 1'b1, 64'h0);

    // Released tags are not visible until the following cycle.
    apply(1, 0, 1, 5, 1, 9);
    exp_push("rel_no_bypass", 0, -1, -1, 0, -1);
    apply(1, 1, 0, 0, 0, 0);
    exp_push("after_rel", 1, 5, 9, 2, -1, 1'b1, 64'h220);

    // Lone slot-2 release, then lone slot-2 allocation.
    apply(0, 0, 0, 0, 1, 7);
    exp_push("lone_rel2", 1, -1, -1, 0, -1);
    apply(0, 1, 0, 0, 0, 0);
    exp_push("req2_only", 1, 7, 7, 1, -1, 1'b1, 64'h80);

    // Tag 0 is never reclaimed; slot 2 compacts into the tail.
    apply(0, 0, 1, 0, 1, 3);
    exp_push("tag0_rel", -1, -1, -1, 0, -1, 1'b1, 64'h0);
    apply(0, 0, 0, 0, 0, 0);
    exp_push("tag0_drop", 1, 3, -1, 1, -1, 1'b1, 64'h8);
    apply(1, 0, 0, 0, 0, 0);
    exp_push("take3", 1, 3, -1, 1, -1);

    // Allocation and release on the same edge.
    apply(0, 0, 1, 20, 1, 21);
    exp_push("rel20_21", -1, -1, -1, 0, -1);
    apply(1, 1, 1, 22, 0, 0);
    exp_push("alloc_rel_same", 1, 20, 21, 2, -1, 1'b1, (64'(1) << 20) | (64'(1) << 21));
    apply(1, 1, 0, 0, 0, 0);
    exp_push("need2_have1", 0, 22, -1, 1, -1, 1'b1, 64'(1) << 22);

    // Duplicate releases: dropped and flagged only with checking enabled.
    apply(0, 0, 1, 22, 0, 0);
    exp_push("dup22", -1, -1, -1, 1, 0);
    apply(0, 0, 1, 12, 1, 12);
    exp_push("dup12", -1, -1, -1, CHK ? 1 : 2, CHK ? 1 : 0);
    apply(0, 0, 0, 0, 0, 0);
    exp_push("after_dup", -1, 22, -1, CHK ? 2 : 4, CHK ? 1 : 0, 1'b1,
             (64'(1) << 22) | (64'(1) << 12));

    // Asynchronous reset between clock edges, mid-burst.
    apply(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_push("async_rst", 1, 32, 33, 32, 0, 1'b1, RST_REGS);
    @(negedge clk);
    #1 rst = 1'b0;
    alloc_req_1 = 1'b0;
    alloc_req_2 = 1'b0;
    apply(0, 0, 0, 0, 0, 0);
    exp_push("post_rst", 1, 32, -1, 32, 0, 1'b1, RST_REGS);

    repeat (2) @(posedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
